dmem_mmio: RTL and testbench

- Data-side memory block directly downstream of the processor's MEM stage.
- Consumes the core's memwrite/memaddr/memwritedata and returns memreaddata in the same cycle. The MEM_WB register captures it at the next edge.
- Decodes the address into three targets: word RAM, a free-running timer with compare/interrupt, and a TX byte FIFO drained through a valid/ready stream.

---
 rtl/dmem_mmio_pkg.sv | 54 +++++
 rtl/dmem_mmio_if.sv | 21 ++
 rtl/dmem_mmio_sync_fifo.sv | 42 ++++
 rtl/dmem_mmio.sv | 126 ++++++++++++
 tb/tb_dmem_mmio.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_mmio_pkg.sv
// Shared constants and address decode for the data-memory / MMIO block.
`ifndef MYDELAY
`define MYDELAY 0
`endif

package dmem_mmio_pkg;

    // MMIO window and register offsets (byte addresses, word aligned).
    localparam logic [31:0] MMIO_BASE  = 32'hFFFF_0000;
    localparam logic [31:0] OFF_TCOUNT = 32'h0000_0000;
    localparam logic [31:0] OFF_TCMP   = 32'h0000_0004;
    localparam logic [31:0] OFF_STATUS = 32'h0000_0008;
    localparam logic [31:0] OFF_TXDATA = 32'h0000_000C;
    localparam logic [31:0] OFF_TCTRL  = 32'h0000_0010;

    // STATUS bit positions.
    localparam int unsigned ST_MATCH = 0;
    localparam int unsigned ST_FULL  = 1;
    localparam int unsigned ST_EMPTY = 2;
    localparam int unsigned ST_OVF   = 3;

    typedef enum logic [2:0] {
        SelNone,
        SelRam,
        SelTcount,
        SelTcmp,
        SelStatus,
        SelTxdata,
        SelTctrl
    } sel_e;

    // Map a byte address to its target; ram_bytes_log2 is log2 of the RAM size in bytes.
    function automatic sel_e decode_addr(logic [31:0] addr, int unsigned ram_bytes_log2);
        logic [31:0] a;
        sel_e        sel;
        a   = addr & 32'hFFFF_FFFC;
        sel = SelNone;
        if ((a >> ram_bytes_log2) == 32'd0) begin
            sel = SelRam;
        end else if (a == MMIO_BASE + OFF_TCOUNT) begin
            sel = SelTcount;
        end else if (a == MMIO_BASE + OFF_TCMP) begin
            sel = SelTcmp;
        end else if (a == MMIO_BASE + OFF_STATUS) begin
            sel = SelStatus;
        end else if (a == MMIO_BASE + OFF_TXDATA) begin
            sel = SelTxdata;
        end else if (a == MMIO_BASE + OFF_TCTRL) begin
            sel = SelTctrl;
        end
        return sel;
    endfunction

endpackage

// File: rtl/dmem_mmio_if.sv
// MEM-stage bus plus TX stream and interrupt between the core and dmem_mmio.
interface dmem_mmio_if;
    logic        memwrite;
    logic [31:0] memaddr;
    logic [31:0] memwritedata;
    logic [31:0] memreaddata;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        irq;

    modport master (
        output memwrite, memaddr, memwritedata, tx_ready,
        input  memreaddata, tx_valid, tx_data, irq
    );

    modport slave (
        input  memwrite, memaddr, memwritedata, tx_ready,
        output memreaddata, tx_valid, tx_data, irq
    );
endinterface

// File: rtl/dmem_mmio_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; accepts a push when full if a pop happens too.
module dmem_mmio_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, rptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rptr_q[AW-1:0]];

    // Pointer advance and storage write; storage itself is not cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q[AW-1:0]] <= wdata;
                wptr_q                <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end
endmodule

// File: rtl/dmem_mmio.sv
// Data memory behind the MEM stage: word RAM, compare timer and TX byte FIFO.
module dmem_mmio
    import dmem_mmio_pkg::*;
#(
    parameter int unsigned RAM_WORDS  = 1024,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned PRESCALE   = 1
) (
    input logic        clk,
    input logic        reset,
    dmem_mmio_if.slave bus
);
    localparam int unsigned   RAM_AW     = $clog2(RAM_WORDS);
    localparam int unsigned   PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    sel_e              sel;
    logic              wr_ram, wr_tcount, wr_tcmp, wr_status, wr_txdata, wr_tctrl;
    logic [31:0]       ram [RAM_WORDS];
    logic [RAM_AW-1:0] ram_idx;
    logic [31:0]       tcount_q, tcount_d, tcmp_q;
    logic [PW-1:0]     presc_q, presc_d;
    logic [1:0]        tctrl_q;
    logic              match_q, ovf_q;
    logic              tick, match_set, ovf_set;
    logic              fifo_full, fifo_empty, fifo_pop;

    assign sel       = decode_addr(bus.memaddr, RAM_AW + 2);
    assign ram_idx   = bus.memaddr[RAM_AW+1:2];
    assign wr_ram    = bus.memwrite && (sel == SelRam);
    assign wr_tcount = bus.memwrite && (sel == SelTcount);
    assign wr_tcmp   = bus.memwrite && (sel == SelTcmp);
    assign wr_status = bus.memwrite && (sel == SelStatus);
    assign wr_txdata = bus.memwrite && (sel == SelTxdata);
    assign wr_tctrl  = bus.memwrite && (sel == SelTctrl);

    assign tick     = tctrl_q[0] && (presc_q == PRESC_LAST);
    assign fifo_pop = !fifo_empty && bus.tx_ready;
    // Dropped byte: full and nothing leaves this cycle to make room.
    assign ovf_set  = wr_txdata && fifo_full && !fifo_pop;

    assign bus.tx_valid = !fifo_empty;
    assign bus.irq      = match_q && tctrl_q[1];

    // RAM store port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_ram) begin
            ram[ram_idx] <= bus.memwritedata;
        end
    end

    // Timer next state; a software load overrides the increment.
    always_comb begin
        tcount_d = tcount_q;
        presc_d  = presc_q;
        if (tctrl_q[0]) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end
        if (tick) begin
            tcount_d = tcount_q + 32'd1;
        end
        if (wr_tcount) begin
            tcount_d = bus.memwritedata;
            presc_d  = '0;
        end
        match_set = (tick || wr_tcount) && (tcount_d == tcmp_q);
    end

    // Timer, control and sticky status registers; set beats write-1-to-clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            tcount_q <= '0;
            tcmp_q   <= '1;
            presc_q  <= '0;
            tctrl_q  <= '0;
            match_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            tcount_q <= tcount_d;
            presc_q  <= presc_d;
            if (wr_tcmp) begin
                tcmp_q <= bus.memwritedata;
            end
            if (wr_tctrl) begin
                tctrl_q <= bus.memwritedata[1:0];
            end
            if (match_set) begin
                match_q <= 1'b1;
            end else if (wr_status && bus.memwritedata[ST_MATCH]) begin
                match_q <= 1'b0;
            end
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (wr_status && bus.memwritedata[ST_OVF]) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // Combinational read mux; unmapped addresses and TXDATA read as zero.
    always_comb begin
        bus.memreaddata = '0;
        case (sel)
            SelRam:    bus.memreaddata = ram[ram_idx];
            SelTcount: bus.memreaddata = tcount_q;
            SelTcmp:   bus.memreaddata = tcmp_q;
            SelStatus: bus.memreaddata = {28'd0, ovf_q, fifo_empty, fifo_full, match_q};
            SelTctrl:  bus.memreaddata = {30'd0, tctrl_q};
            default:   bus.memreaddata = '0;
        endcase
    end

    dmem_mmio_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_txdata),
        .pop   (fifo_pop),
        .wdata (bus.memwritedata[7:0]),
        .rdata (bus.tx_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );
endmodule

// File: tb/tb_dmem_mmio.sv
// Randomised self-checking bench for dmem_mmio against a queue/array reference model.
module tb_dmem_mmio;
    localparam int unsigned RAM_WORDS  = 1024;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam logic [31:0] A_TCOUNT = 32'hFFFF_0000;
    localparam logic [31:0] A_TCMP   = 32'hFFFF_0004;
    localparam logic [31:0] A_STATUS = 32'hFFFF_0008;
    localparam logic [31:0] A_TXDATA = 32'hFFFF_000C;
    localparam logic [31:0] A_TCTRL  = 32'hFFFF_0010;

    logic clk = 1'b0;
    logic reset;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    logic [31:0] ram_model [int];

    dmem_mmio_if bus ();

    dmem_mmio #(
        .RAM_WORDS  (RAM_WORDS),
        .FIFO_DEPTH (FIFO_DEPTH),
        .PRESCALE   (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        bus.memaddr      = a;
        bus.memwritedata = d;
        bus.memwrite     = 1'b1;
        step();
        bus.memwrite     = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, output logic [31:0] d);
        bus.memwrite = 1'b0;
        bus.memaddr  = a;
        #1;
        d = bus.memreaddata;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        total_cnt++;
        if (bus.tx_valid !== 1'b0) $display("FAIL reset_tx_valid got %b want 0", bus.tx_valid);
        else pass_cnt++;
        total_cnt++;
        if (bus.irq !== 1'b0) $display("FAIL reset_irq got %b want 0", bus.irq);
        else pass_cnt++;
        load(A_STATUS, d);
        total_cnt++;
        if (d !== 32'h4) $display("FAIL reset_status got %h want %h", d, 32'h4);
        else pass_cnt++;
        load(A_TCOUNT, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL reset_tcount got %h want %h", d, 32'h0);
        else pass_cnt++;
        step();
        load(A_TCMP, d);
        total_cnt++;
        if (d !== 32'hFFFF_FFFF) $display("FAIL reset_tcmp got %h want %h", d, 32'hFFFF_FFFF);
        else pass_cnt++;
        load(A_TCTRL, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL reset_tctrl got %h want %h", d, 32'h0);
        else pass_cnt++;
        step();
    endtask

    task automatic test_ram();
        logic [31:0] d, a, v;
        int unsigned idx;
        store(32'h0000_0010, 32'hDEADBEEF);
        ram_model[4] = 32'hDEADBEEF;
        load(32'h0000_0010, d);
        total_cnt++;
        if (d !== 32'hDEADBEEF) $display("FAIL ram_basic got %h want %h", d, 32'hDEADBEEF);
        else pass_cnt++;
        for (int i = 0; i < 16; i++) begin
            idx = $urandom_range(5, RAM_WORDS - 1);
            v   = $urandom;
            a   = (32'(idx) << 2) | 32'($urandom_range(0, 3));
            store(a, v);
            ram_model[int'(idx)] = v;
        end
        foreach (ram_model[k]) begin
            load(32'(k) << 2, d);
            total_cnt++;
            if (d !== ram_model[k]) $display("FAIL ram_rand word %0d got %h want %h", k, d, ram_model[k]);
            else pass_cnt++;
            step();
        end
        // Read while writing the same word sees the old contents.
        bus.memaddr      = 32'h0000_0010;
        bus.memwritedata = 32'h0BAD_F00D;
        bus.memwrite     = 1'b1;
        #1;
        total_cnt++;
        if (bus.memreaddata !== ram_model[4])
            $display("FAIL ram_rdw got %h want %h", bus.memreaddata, ram_model[4]);
        else pass_cnt++;
        step();
        bus.memwrite = 1'b0;
        ram_model[4] = 32'h0BAD_F00D;
        load(32'h0000_0010, d);
        total_cnt++;
        if (d !== 32'h0BAD_F00D) $display("FAIL ram_after_write got %h want %h", d, 32'h0BAD_F00D);
        else pass_cnt++;
        step();
    endtask

    task automatic test_unmapped();
        logic [31:0] d;
        store(32'h0000_0000, 32'hA5A5_5A5A);
        ram_model[0] = 32'hA5A5_5A5A;
        store(32'h0000_0FFC, 32'h1357_9BDF);
        ram_model[RAM_WORDS - 1] = 32'h1357_9BDF;
        store(32'h0000_1000, 32'h1111_2222);
        store(32'h0000_2000, 32'h1234_5678);
        store(32'hFFFF_0014, 32'h0000_0003);
        load(32'h0000_2000, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL unmapped_2000 got %h want 0", d);
        else pass_cnt++;
        load(32'h0000_1000, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL unmapped_ram_end got %h want 0", d);
        else pass_cnt++;
        load(32'hFFFF_0014, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL unmapped_mmio got %h want 0", d);
        else pass_cnt++;
        step();
        load(32'h0000_0000, d);
        total_cnt++;
        if (d !== ram_model[0]) $display("FAIL unmapped_alias word0 got %h want %h", d, ram_model[0]);
        else pass_cnt++;
        load(32'h0000_0FFC, d);
        total_cnt++;
        if (d !== ram_model[RAM_WORDS - 1]) $display("FAIL ram_last_word got %h want %h", d, ram_model[RAM_WORDS - 1]);
        else pass_cnt++;
        load(A_TCTRL, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL unmapped_side_effect tctrl got %h want 0", d);
        else pass_cnt++;
        step();
    endtask

    task automatic test_timer_match();
        logic [31:0] d;
        logic        exp;
        // TCOUNT is 0 and the timer is stopped when this starts.
        store(A_TCMP, 32'd5);
        store(A_TCTRL, 32'h3);
        for (int i = 1; i <= 7; i++) begin
            step();
            exp = (i >= 5);
            load(A_STATUS, d);
            total_cnt++;
            if (d[0] !== exp) $display("FAIL timer_match count %0d got %b want %b", i, d[0], exp);
            else pass_cnt++;
            total_cnt++;
            if (bus.irq !== exp) $display("FAIL timer_irq count %0d got %b want %b", i, bus.irq, exp);
            else pass_cnt++;
        end
        store(A_STATUS, 32'h1);
        total_cnt++;
        if (bus.irq !== 1'b0) $display("FAIL timer_irq_clear got %b want 0", bus.irq);
        else pass_cnt++;
        load(A_STATUS, d);
        total_cnt++;
        if (d[0] !== 1'b0) $display("FAIL timer_match_clear got %b want 0", d[0]);
        else pass_cnt++;
        store(A_TCTRL, 32'h0);
    endtask

    task automatic test_timer_load();
        logic [31:0] d, v;
        int unsigned n;
        store(A_TCTRL, 32'h1);
        store(A_TCOUNT, 32'hFFFF_FFFF);
        load(A_TCOUNT, d);
        total_cnt++;
        if (d !== 32'hFFFF_FFFF) $display("FAIL timer_load got %h want %h", d, 32'hFFFF_FFFF);
        else pass_cnt++;
        step();
        load(A_TCOUNT, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL timer_wrap got %h want 0", d);
        else pass_cnt++;
        for (int t = 0; t < 3; t++) begin
            v = $urandom;
            n = $urandom_range(1, 20);
            store(A_TCOUNT, v);
            repeat (n) step();
            load(A_TCOUNT, d);
            total_cnt++;
            if (d !== v + n) $display("FAIL timer_run load %h after %0d got %h want %h", v, n, d, v + n);
            else pass_cnt++;
        end
        store(A_TCTRL, 32'h0);
        store(A_STATUS, 32'h9);
    endtask

    task automatic test_fifo_fill();
        logic [31:0] d;
        logic [7:0]  b;
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            b = 8'h41 + 8'(i);
            store(A_TXDATA, {$urandom_range(0, 32'hFF_FFFF), b});
        end
        load(A_STATUS, d);
        total_cnt++;
        if (d !== 32'h2) $display("FAIL fifo_full_status got %h want %h", d, 32'h2);
        else pass_cnt++;
        store(A_TXDATA, 32'h49);
        load(A_STATUS, d);
        total_cnt++;
        if (d !== 32'hA) $display("FAIL fifo_ovf_status got %h want %h", d, 32'hA);
        else pass_cnt++;
        total_cnt++;
        if (bus.tx_data !== 8'h41) $display("FAIL fifo_head_hold got %h want %h", bus.tx_data, 8'h41);
        else pass_cnt++;
        step();
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b = 8'h41 + 8'(i);
            total_cnt++;
            if (bus.tx_valid !== 1'b1 || bus.tx_data !== b)
                $display("FAIL fifo_drain %0d got valid %b data %h want valid 1 data %h", i, bus.tx_valid, bus.tx_data, b);
            else pass_cnt++;
            step();
        end
        bus.tx_ready = 1'b0;
        load(A_STATUS, d);
        total_cnt++;
        if (d !== 32'hC) $display("FAIL fifo_empty_ovf got %h want %h", d, 32'hC);
        else pass_cnt++;
        load(A_TXDATA, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL txdata_read got %h want 0", d);
        else pass_cnt++;
        store(A_STATUS, 32'h8);
        load(A_STATUS, d);
        total_cnt++;
        if (d !== 32'h4) $display("FAIL ovf_clear got %h want %h", d, 32'h4);
        else pass_cnt++;
        step();
    endtask

    task automatic test_fifo_full_pop();
        logic [31:0] d;
        logic [7:0]  exp_q [$];
        logic [7:0]  b;
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            b = 8'h60 + 8'(i);
            store(A_TXDATA, {24'h0, b});
            exp_q.push_back(b);
        end
        bus.memaddr      = A_TXDATA;
        bus.memwritedata = 32'h55;
        bus.memwrite     = 1'b1;
        bus.tx_ready     = 1'b1;
        step();
        bus.memwrite = 1'b0;
        bus.tx_ready = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(8'h55);
        load(A_STATUS, d);
        total_cnt++;
        if (d !== 32'h2) $display("FAIL fifo_push_pop_full got %h want %h", d, 32'h2);
        else pass_cnt++;
        step();
        bus.tx_ready = 1'b1;
        while (exp_q.size() > 0) begin
            b = exp_q.pop_front();
            total_cnt++;
            if (bus.tx_valid !== 1'b1 || bus.tx_data !== b)
                $display("FAIL fifo_full_pop_order got valid %b data %h want valid 1 data %h", bus.tx_valid, bus.tx_data, b);
            else pass_cnt++;
            step();
        end
        bus.tx_ready = 1'b0;
        load(A_STATUS, d);
        total_cnt++;
        if (d !== 32'h4) $display("FAIL fifo_full_pop_end got %h want %h", d, 32'h4);
        else pass_cnt++;
        step();
    endtask

    task automatic test_fifo_random();
        logic [31:0] d, exp;
        logic [7:0]  q [$];
        logic        ovf_m, push, rdy, pop;
        int          fails;
        ovf_m = 1'b0;
        fails = 0;
        for (int c = 0; c < 300; c++) begin
            push             = ($urandom_range(0, 99) < 60);
            rdy              = ($urandom_range(0, 99) < 40);
            bus.memaddr      = push ? A_TXDATA : A_STATUS;
            bus.memwritedata = $urandom;
            bus.memwrite     = push;
            bus.tx_ready     = rdy;
            #1;
            total_cnt++;
            if (bus.tx_valid !== (q.size() != 0)) begin
                $display("FAIL fifo_rand_valid cycle %0d got %b want %b", c, bus.tx_valid, q.size() != 0);
                fails++;
            end else if (q.size() != 0 && bus.tx_data !== q[0]) begin
                $display("FAIL fifo_rand_data cycle %0d got %h want %h", c, bus.tx_data, q[0]);
                fails++;
            end else pass_cnt++;
            pop = (q.size() != 0) && rdy;
            if (push) begin
                if (q.size() < FIFO_DEPTH || pop) q.push_back(bus.memwritedata[7:0]);
                else ovf_m = 1'b1;
            end
            if (pop) void'(q.pop_front());
            step();
        end
        bus.memwrite = 1'b0;
        bus.tx_ready = 1'b0;
        exp = {28'd0, ovf_m, q.size() == 0, q.size() == FIFO_DEPTH, 1'b0};
        load(A_STATUS, d);
        total_cnt++;
        if (d !== exp) $display("FAIL fifo_rand_status got %h want %h", d, exp);
        else pass_cnt++;
        bus.tx_ready = 1'b1;
        repeat (FIFO_DEPTH + 1) step();
        bus.tx_ready = 1'b0;
        store(A_STATUS, 32'h8);
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) store(A_TXDATA, $urandom);
        store(A_TCOUNT, 32'd100);
        store(A_TCMP, 32'h0000_1234);
        store(A_TCTRL, 32'h2);
        load(A_TCOUNT, d);
        total_cnt++;
        if (d !== 32'd100) $display("FAIL pre_reset_tcount got %h want %h", d, 32'd100);
        else pass_cnt++;
        reset = 1'b1;
        step();
        reset = 1'b0;
        total_cnt++;
        if (bus.tx_valid !== 1'b0) $display("FAIL mid_reset_tx_valid got %b want 0", bus.tx_valid);
        else pass_cnt++;
        load(A_TCOUNT, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL mid_reset_tcount got %h want 0", d);
        else pass_cnt++;
        load(A_TCMP, d);
        total_cnt++;
        if (d !== 32'hFFFF_FFFF) $display("FAIL mid_reset_tcmp got %h want %h", d, 32'hFFFF_FFFF);
        else pass_cnt++;
        step();
        load(A_STATUS, d);
        total_cnt++;
        if (d !== 32'h4) $display("FAIL mid_reset_status got %h want %h", d, 32'h4);
        else pass_cnt++;
        load(A_TCTRL, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL mid_reset_tctrl got %h want 0", d);
        else pass_cnt++;
        total_cnt++;
        if (bus.tx_valid !== 1'b0) $display("FAIL mid_reset_tx_valid_later got %b want 0", bus.tx_valid);
        else pass_cnt++;
        step();
        foreach (ram_model[k]) begin
            load(32'(k) << 2, d);
            total_cnt++;
            if (d !== ram_model[k]) $display("FAIL ram_after_reset word %0d got %h want %h", k, d, ram_model[k]);
            else pass_cnt++;
            step();
        end
    endtask

    initial begin
        reset            = 1'b1;
        bus.memwrite     = 1'b0;
        bus.memaddr      = 32'h0;
        bus.memwritedata = 32'h0;
        bus.tx_ready     = 1'b0;
        test_reset();
        test_ram();
        test_unmapped();
        test_timer_match();
        test_timer_load();
        test_fifo_fill();
        test_fifo_full_pop();
        test_fifo_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
